font_rom_arbiter: RTL
=====================

# font_rom_arbiter

Shares the single synchronous-read font ROM (2048×8, 1-cycle read latency) between several character-rendering requesters: the clock-digit text writer, plus overlay or banner writers added later. Requesters post a glyph-row address with a level request. The arbiter grants one address per cycle, drives the ROM address, and returns the ROM byte tagged with a one-hot valid to the winner two cycles after arbitration. It sits between the text writers and `font_rom` inside the VGA painter.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `AW`, 11: ROM address width.
- `DW`, 8: ROM data width.

- `clk` in 1: pixel-domain system clock.
- `reset` in 1: synchronous, active-low reset.
- `req` in NREQ: level request per requester.
- `addr` in NREQ*AW: flattened request addresses; requester i occupies bits [i*AW +: AW].
- `gnt` out NREQ: one-hot, registered; address of requester i accepted.
- `rvalid` out NREQ: one-hot, registered; `rdata` belongs to requester i.
- `rdata` out DW: ROM data broadcast to all requesters (direct from `rom_data`).
- `rom_addr` out AW: registered address to `font_rom`.
- `rom_data` in DW: `font_rom` registered output.
- `busy` out 1: `|gnt | |rvalid`.

## Operation
- Eligible set each cycle: `req & ~gnt`. A requester already granted this cycle is masked so one request is never granted twice.
- Winner selection:
  - With round-robin enabled, search starts at `ptr+1` modulo NREQ.
  - Otherwise, the lowest index wins.
- If the eligible set is non-empty, at the clock edge:
  - `gnt` ← one-hot(winner).
  - `rom_addr` ← `addr[winner]`.
  - `ptr` ← winner.
- If the eligible set is empty: `gnt` ← 0, and `rom_addr` and `ptr` hold.
- `rvalid` ← `gnt` delayed one cycle. This is a 1-stage tag pipeline that matches ROM latency.
- Requester contract:
  - Hold `req` and `addr` stable until `gnt[i]` is sampled high.
  - Deassert, or present a new address, in the cycle after `gnt`.
  - Dropping `req` before grant withdraws the request; nothing is returned.
- Aggregate throughput is 1 grant per cycle. A single requester can get at most 1 grant per 2 cycles because of the masking.
- Reset values: `gnt`=0, `rvalid`=0, `rom_addr`=0, `ptr`=NREQ-1 (so requester 0 wins first), `busy`=0. `rdata` is not reset; it follows `rom_data`.
- Reset mid-operation: all in-flight grants and tags are discarded. No `rvalid` is produced for addresses issued before reset.
- `addr` bits of non-requesting requesters are don't-care.

## Timing
- Cycle N: `req[i]` high and i wins arbitration.
- N+1: `gnt[i]`=1 and `rom_addr`=`addr[i]`. The ROM samples `rom_addr` at the end of N+1.
- N+2: `rvalid[i]`=1 and `rdata`=ROM[`addr[i]`].
- Request-to-data latency is 2 cycles; this is fixed and deterministic, with no stalls once granted.
- Worst-case wait before grant:
  - Round-robin: NREQ-1 cycles.
  - Fixed priority: unbounded for the higher indices.
- No combinational path from `req`/`addr` to any output.

## Configuration
- `FONT_ARB_RR_EN` defined: round-robin arbitration using `ptr` as described above.
- `FONT_ARB_RR_EN` undefined: fixed priority (index 0 highest). `ptr` is not implemented. The text writer must be requester 0.

## Structure
- Package `font_arb_pkg` holds:
  - `FONT_AW`=11, `FONT_DW`=8, `FONT_ROM_LATENCY`=1, `FONT_ARB_MAX_REQ`=8.
  - A function that slices flattened address buses.
- One combinational sub-module, `rr_onehot_picker`: inputs are the eligible vector and the start index; output is the one-hot winner plus its encoded index. In fixed mode it is called with start index 0.
- Arbiter top contains the grant/address registers, the pointer and the `rvalid` tag stage.

## Test plan
- Reset low for 3 cycles with `req`=2'b11 → `gnt`=0, `rvalid`=0, `rom_addr`=0. First release cycle grants requester 0.
- Single request: `req`=01 with `addr0`=0x230 in cycle N → `gnt`=01 at N+1, `rom_addr`=0x230, `rvalid`=01 at N+2 with `rdata`=ROM[0x230]. No second grant.
- Both requesting continuously (RR build), addresses 0x100/0x200 → grants alternate 01, 10, 01, 10… every cycle. `rvalid` mirrors the same sequence 1 cycle later with matching data.
- Fixed-priority build, both requesting for 6 cycles; requester 0 holds `req` through N+1, then toggles → requester 1 is granted only in cycles where requester 0 is masked or idle.
- Reset asserted the cycle after `gnt`=10 → no `rvalid` appears. `ptr` returns to NREQ-1 and the next grant goes to requester 0.
- `req1` pulsed for one cycle while requester 0 wins → requester 1 is never granted and no `rvalid[1]` is produced.

Source files
------------

// File: rtl/font_arb_pkg.sv
// Shared constants and helpers for the font ROM arbiter.
// Arbitration mode is selected by the FONT_ARB_RR_EN macro in font_rom_arbiter.
package font_arb_pkg;

  localparam int FONT_AW          = 11;
  localparam int FONT_DW          = 8;
  localparam int FONT_ROM_LATENCY = 1;
  localparam int FONT_ARB_MAX_REQ = 8;

  // Extract requester idx's address from a flattened bus padded to the maximum requester count.
  function automatic logic [FONT_AW-1:0] addr_slice(
    input logic [FONT_ARB_MAX_REQ*FONT_AW-1:0] bus,
    input int unsigned                         idx
  );
    return bus[idx*FONT_AW +: FONT_AW];
  endfunction

endpackage

// File: rtl/rr_onehot_picker.sv
// Combinational picker: first set bit of elig, searching upward from start and wrapping.
// Returns the winner as both a one-hot vector and an encoded index.
module rr_onehot_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(start) + k) % N;
      if (!any && elig[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/font_rom_arbiter.sv
// Shares one synchronous-read font ROM between NREQ glyph-row requesters.
// Define FONT_ARB_RR_EN for round-robin; otherwise fixed priority with index 0 highest.
module font_rom_arbiter
  import font_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = FONT_AW,
  parameter int DW   = FONT_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic [AW-1:0]     rom_addr,
  input  logic [DW-1:0]     rom_data,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] win_onehot;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   start_idx;
  logic            win_any;
  logic [AW-1:0]   win_addr;

  // Masking the current grant stops a held request from being accepted twice.
  assign elig = req & ~gnt;

`ifdef FONT_ARB_RR_EN
  logic [IW-1:0] ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= IW'(NREQ - 1);
    end else if (win_any) begin
      ptr <= win_idx;
    end
  end

  assign start_idx = (ptr == IW'(NREQ - 1)) ? '0 : ptr + 1'b1;
`else
  assign start_idx = '0;
`endif

  rr_onehot_picker #(
    .N  (NREQ),
    .IW (IW)
  ) u_picker (
    .elig   (elig),
    .start  (start_idx),
    .onehot (win_onehot),
    .idx    (win_idx),
    .any    (win_any)
  );

  generate
    if (AW == FONT_AW && NREQ <= FONT_ARB_MAX_REQ) begin : g_pkg_slice
      logic [FONT_ARB_MAX_REQ*FONT_AW-1:0] addr_bus;
      always_comb begin
        addr_bus                = '0;
        addr_bus[NREQ*AW-1:0]   = addr;
      end
      assign win_addr = addr_slice(addr_bus, 32'(win_idx));
    end else begin : g_direct_slice
      assign win_addr = addr[32'(win_idx)*AW +: AW];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt      <= '0;
      rvalid   <= '0;
      rom_addr <= '0;
    end else begin
      gnt    <= win_any ? win_onehot : '0;
      rvalid <= gnt;
      if (win_any) begin
        rom_addr <= win_addr;
      end
    end
  end

  assign rdata = rom_data;
  assign busy  = (|gnt) | (|rvalid);

endmodule
